uart_host_loader: RTL and testbench
===================================

# uart_host_loader

Host-side initiator for the UART program/dump link. On `start` it sends a calibration byte, streams an instruction image of 2^IMEM_BYTE_ADDR_WIDTH bytes over `tx_out`, then receives a data-memory dump of 2^DMEM_BYTE_ADDR_WIDTH bytes on `rx_in` and writes it into a word-wide dump memory. It is the far end of the device's UART loader. It is used on the FPGA host board and as a synthesizable bench driver.

## Interface
- CYCLES_PER_BIT, 16, clocks per UART bit; must be even and ≥ 8.
- COUNTER_WIDTH, 24, width of the bit-timing and timeout counters.
- IMEM_BYTE_ADDR_WIDTH, 6, log2 of the image size in bytes; must be ≥ 2.
- DMEM_BYTE_ADDR_WIDTH, 6, log2 of the dump size in bytes; must be ≥ 2.
- RX_TIMEOUT_CYCLES, 2^20, idle cycles allowed in RECV before a start bit arrives.
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assertion, active-low
- start  in  1  single-cycle request that begins a transfer
- tx_out  out  1  UART serial output, 8N1, LSB first
- rx_in  in  1  UART serial input, asynchronous to clk
- img_rd_en  out  1  image word read strobe
- img_addr  out  IMEM_BYTE_ADDR_WIDTH-2  image word address
- img_rd_data  in  32  image word; valid the cycle after img_rd_en
- dump_wr_en  out  1  dump write strobe
- dump_addr  out  DMEM_BYTE_ADDR_WIDTH-2  dump word address
- dump_byte_en  out  4  one-hot byte lane enable
- dump_wr_data  out  32  received byte replicated on all four lanes
- busy  out  1  high from the cycle after an accepted start until done or error
- done  out  1  sticky; transfer completed
- error  out  1  sticky; framing error or timeout

## Operation
- Reset values: tx_out=1; all other outputs 0; state IDLE; byte counters 0.
- States and transitions:
  - IDLE: on start go to CAL. Accepting start clears done and error.
  - CAL: transmit 0x55, then go to FETCH.
  - FETCH: assert img_rd_en, img_addr = byte_addr[IMEM-1:2], then go to WAIT.
  - WAIT: latch lane byte_addr[1:0] of img_rd_data (little-endian; lane k = bits 8k+7:8k), then go to SEND.
  - SEND: transmit the byte and increment byte_addr. After the last byte go to RECV; otherwise go to FETCH.
  - RECV: receive bytes until 2^DMEM bytes are written, then go to DONE. A framing error or timeout goes to ERROR.
  - DONE: assert done and return to IDLE.
  - ERROR: assert error and return to IDLE.
- start is ignored while busy. done and error stay high in IDLE until the next accepted start.
- TX frame: start bit 0, data bits 0..7, stop bit 1. Each bit lasts exactly CYCLES_PER_BIT cycles. tx_out is registered.
- RX path:
  - rx_in passes through a 2-flop synchronizer.
  - A synchronized 1→0 edge begins a frame. It is checked again CYCLES_PER_BIT/2 cycles later; if it is high then, it is a false start and the receiver resumes hunting with no error.
  - Data bits are sampled at CYCLES_PER_BIT intervals from the mid-start point, then the stop bit is sampled.
  - A stop bit of 0 is a framing error.
- Bytes arriving on rx_in outside RECV are ignored. A frame already in progress when RECV is entered is discarded.
- Dump write per received byte:
  - dump_wr_en pulses for one cycle.
  - dump_addr = dump_byte_addr[DMEM-1:2].
  - dump_byte_en = 1 << dump_byte_addr[1:0].
  - dump_wr_data = {4{byte}}.
  - dump_byte_addr then increments.
- Timeout: the counter resets on RECV entry and at every accepted start bit. When it reaches RX_TIMEOUT_CYCLES, go to ERROR.
- Byte address counters are exactly IMEM/DMEM bits wide. The last byte is detected at the all-ones value; counters never wrap during a transfer.
- Asynchronous reset mid-transfer forces every reset value immediately. tx_out returns to 1 and a partial frame is abandoned.

## Timing
- start in cycle 0: busy=1 and tx_out=0 (CAL start bit) from cycle 1.
- Byte period is 10·CYCLES_PER_BIT cycles.
- Between consecutive image bytes (and CAL→first image byte), tx_out is idle high for exactly 2 cycles (FETCH, WAIT).
- First image start bit appears at cycle 1 + 10·CPB + 2.
- RECV is entered the cycle after the last stop bit ends.
- dump_wr_en asserts 1 cycle after the stop-bit sample. Input edge to write latency is set by the synchronizer (2 cycles) plus the bit timing.
- done=1 and busy=0 in the cycle after the last dump write.
- error=1 and busy=0 in the cycle after the framing-error sample or timeout.

## Test plan
- Image words 0x03020100, 0x07060504 … (CPB=16) -> tx_out shows 0x55 then bytes 0x00,0x01,…,0x3F in order. Each bit is 16 cycles, each inter-byte gap is 2 idle cycles, and img_addr steps 0..15 with four reads per word.
- Bench UART returns bytes 0xA0+i, i=0..63 -> 64 dump_wr_en pulses; dump_byte_en cycles 0001,0010,0100,1000; dump_addr 0..15. Then done=1, busy=0, error=0.
- Low glitch of 4 cycles on rx_in during RECV -> no write and no error; the next valid byte is written to byte address 0.
- Stop bit driven 0 on the 5th dump byte -> error=1, busy=0, no 5th write; a following start clears error.
- No reply with RX_TIMEOUT_CYCLES=1000 -> error exactly 1000 cycles after RECV entry. A start pulse while busy is ignored.
- rst_n low mid-SEND -> tx_out=1 and all outputs 0 immediately. After release, start begins again from CAL.

Source files
------------

// File: rtl/uart_host_loader.sv
// ============================================================================
// Module   : uart_host_loader
// Purpose  : Host-side UART initiator: sends a calibration byte and an
//            instruction image, then captures a data-memory dump.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_host_loader #(
    parameter int CYCLES_PER_BIT       = 16,
    parameter int COUNTER_WIDTH        = 24,
    parameter int IMEM_BYTE_ADDR_WIDTH = 6,
    parameter int DMEM_BYTE_ADDR_WIDTH = 6,
    parameter int RX_TIMEOUT_CYCLES    = 1 << 20
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            tx_out,
    input  logic                            rx_in,
    output logic                            img_rd_en,
    output logic [IMEM_BYTE_ADDR_WIDTH-3:0] img_addr,
    input  logic [31:0]                     img_rd_data,
    output logic                            dump_wr_en,
    output logic [DMEM_BYTE_ADDR_WIDTH-3:0] dump_addr,
    output logic [3:0]                      dump_byte_en,
    output logic [31:0]                     dump_wr_data,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam logic [COUNTER_WIDTH-1:0] c_bit_last  = COUNTER_WIDTH'(CYCLES_PER_BIT - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_half_last = COUNTER_WIDTH'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [COUNTER_WIDTH-1:0] c_to_last   = COUNTER_WIDTH'(RX_TIMEOUT_CYCLES - 1);
    localparam logic [IMEM_BYTE_ADDR_WIDTH-1:0] c_img_last = '1;
    localparam logic [DMEM_BYTE_ADDR_WIDTH-1:0] c_dmp_last = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CAL, S_FETCH, S_WAIT, S_SEND, S_RECV, S_DONE, S_ERROR
    } state_t;

    state_t r_state, w_next;

    logic [IMEM_BYTE_ADDR_WIDTH-1:0] r_byte_addr;
    logic [DMEM_BYTE_ADDR_WIDTH-1:0] r_dump_addr;
    logic                            r_done, r_error;

    logic                     r_tx_active, r_tx_out;
    logic [8:0]               r_tx_shift;
    logic [3:0]               r_tx_bit;
    logic [COUNTER_WIDTH-1:0] r_tx_cnt;
    logic                     w_tx_load, w_tx_last;
    logic [7:0]               w_tx_data;

    logic                     r_rx_meta, r_rx_sync, r_rx_prev;
    logic                     r_rx_busy, r_rx_valid;
    logic [3:0]               r_rx_bit;
    logic [COUNTER_WIDTH-1:0] r_rx_cnt, r_to_cnt;
    logic [7:0]               r_rx_shift;
    logic                     w_recv, w_rx_tick, w_rx_start_ok, w_rx_ferr, w_timeout;
    logic                     w_accept, w_dump_we;

    assign w_accept      = (r_state == S_IDLE) && start;
    assign w_recv        = (r_state == S_RECV);
    assign w_tx_last     = r_tx_active && (r_tx_bit == 4'd9) && (r_tx_cnt == c_bit_last);
    assign w_rx_tick     = r_rx_busy &&
                           (r_rx_cnt == ((r_rx_bit == 4'd0) ? c_half_last : c_bit_last));
    assign w_rx_start_ok = w_rx_tick && (r_rx_bit == 4'd0) && !r_rx_sync;
    assign w_rx_ferr     = w_rx_tick && (r_rx_bit == 4'd9) && !r_rx_sync;
    assign w_timeout     = w_recv && (r_to_cnt == c_to_last);
    assign w_dump_we     = w_recv && r_rx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_tx_load = 1'b0;
        w_tx_data = 8'h55;
        case (r_state)
            S_IDLE:  if (start) begin
                         w_next    = S_CAL;
                         w_tx_load = 1'b1;
                     end
            S_CAL:   if (w_tx_last) w_next = S_FETCH;
            S_FETCH: w_next = S_WAIT;
            S_WAIT:  begin
                         w_tx_load = 1'b1;
                         w_tx_data = img_rd_data[{r_byte_addr[1:0], 3'b000} +: 8];
                         w_next    = S_SEND;
                     end
            S_SEND:  if (w_tx_last) w_next = (r_byte_addr == c_img_last) ? S_RECV : S_FETCH;
            S_RECV:  begin
                         if (w_rx_ferr || w_timeout)                   w_next = S_ERROR;
                         else if (w_dump_we && r_dump_addr == c_dmp_last) w_next = S_DONE;
                     end
            S_DONE:  w_next = S_IDLE;
            S_ERROR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_addr <= '0;
            r_dump_addr <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else if (w_accept) begin
            r_byte_addr <= '0;
            r_dump_addr <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (r_state == S_SEND && w_tx_last && r_byte_addr != c_img_last)
                r_byte_addr <= r_byte_addr + IMEM_BYTE_ADDR_WIDTH'(1);
            if (w_dump_we && r_dump_addr != c_dmp_last)
                r_dump_addr <= r_dump_addr + DMEM_BYTE_ADDR_WIDTH'(1);
            if (w_next == S_DONE)  r_done  <= 1'b1;
            if (w_next == S_ERROR) r_error <= 1'b1;
        end
    end

    // Transmitter: start bit is driven on the load edge, stop bit is the shifted-in 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_active <= 1'b0;
            r_tx_out    <= 1'b1;
            r_tx_shift  <= '1;
            r_tx_bit    <= '0;
            r_tx_cnt    <= '0;
        end else if (w_tx_load) begin
            r_tx_active <= 1'b1;
            r_tx_out    <= 1'b0;
            r_tx_shift  <= {1'b1, w_tx_data};
            r_tx_bit    <= '0;
            r_tx_cnt    <= '0;
        end else if (r_tx_active) begin
            if (r_tx_cnt == c_bit_last) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    r_tx_active <= 1'b0;
                end else begin
                    r_tx_out   <= r_tx_shift[0];
                    r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + COUNTER_WIDTH'(1);
            end
        end
    end

    // Receiver only runs in RECV, so any frame straddling RECV entry is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_bit   <= '0;
            r_rx_cnt   <= '0;
            r_rx_shift <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_rx_meta  <= rx_in;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            r_to_cnt   <= (!w_recv || w_rx_start_ok) ? '0 : r_to_cnt + COUNTER_WIDTH'(1);
            if (!w_recv) begin
                r_rx_busy <= 1'b0;
            end else if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_sync) begin
                    r_rx_busy <= 1'b1;
                    r_rx_bit  <= '0;
                    r_rx_cnt  <= '0;
                end
            end else if (w_rx_tick) begin
                r_rx_cnt <= '0;
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_sync) r_rx_busy <= 1'b0;
                    else           r_rx_bit  <= 4'd1;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_busy  <= 1'b0;
                    r_rx_valid <= r_rx_sync;
                end else begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 4'd1;
                end
            end else begin
                r_rx_cnt <= r_rx_cnt + COUNTER_WIDTH'(1);
            end
        end
    end

    assign tx_out       = r_tx_out;
    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
    assign done         = r_done;
    assign error        = r_error;
    assign img_rd_en    = (r_state == S_FETCH);
    assign img_addr     = r_byte_addr[IMEM_BYTE_ADDR_WIDTH-1:2];
    assign dump_wr_en   = w_dump_we;
    assign dump_addr    = r_dump_addr[DMEM_BYTE_ADDR_WIDTH-1:2];
    assign dump_byte_en = w_dump_we ? (4'b0001 << r_dump_addr[1:0]) : 4'b0000;
    assign dump_wr_data = w_dump_we ? {4{r_rx_shift}} : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_uart_host_loader.sv
// ============================================================================
// Module   : tb_uart_host_loader
// Purpose  : Self-checking bench for uart_host_loader with a byte-stream model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_host_loader;

    localparam int CPB  = 16;
    localparam int CW   = 24;
    localparam int IAW  = 6;
    localparam int DAW  = 6;
    localparam int TO   = 1000;
    localparam int NIMG = 1 << IAW;
    localparam int NDMP = 1 << DAW;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rx_in = 1'b1;
    logic [31:0] img_rd_data = 32'h0;
    logic tx_out, img_rd_en, dump_wr_en, busy, done, error;
    logic [IAW-3:0] img_addr;
    logic [DAW-3:0] dump_addr;
    logic [3:0]     dump_byte_en;
    logic [31:0]    dump_wr_data;

    uart_host_loader #(
        .CYCLES_PER_BIT(CPB), .COUNTER_WIDTH(CW), .IMEM_BYTE_ADDR_WIDTH(IAW),
        .DMEM_BYTE_ADDR_WIDTH(DAW), .RX_TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_out(tx_out), .rx_in(rx_in),
        .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rd_data(img_rd_data),
        .dump_wr_en(dump_wr_en), .dump_addr(dump_addr), .dump_byte_en(dump_byte_en),
        .dump_wr_data(dump_wr_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;
    logic [7:0]  img_bytes [NIMG];
    logic [31:0] img_mem   [NIMG/4];
    logic [7:0]  reply     [NDMP];
    int          rd_addr_q [$];
    int          wr_addr_q [$];
    logic [3:0]  wr_be_q   [$];
    logic [31:0] wr_data_q [$];
    int last_wr_cyc = -1, done_rise_cyc = -1, err_rise_cyc = -1;
    logic done_d = 1'b0, err_d = 1'b0;

    // Image memory and observation of the memory-side ports.
    always @(negedge clk) begin
        if (img_rd_en) begin
            img_rd_data <= img_mem[img_addr];
            rd_addr_q.push_back(int'(img_addr));
        end
        if (dump_wr_en) begin
            wr_addr_q.push_back(int'(dump_addr));
            wr_be_q.push_back(dump_byte_en);
            wr_data_q.push_back(dump_wr_data);
            last_wr_cyc <= cyc;
        end
        if (done && !done_d) done_rise_cyc <= cyc;
        if (error && !err_d) err_rise_cyc <= cyc;
        done_d <= done;
        err_d  <= error;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic new_image(input bit zero_first);
        for (int i = 0; i < NIMG; i++) img_bytes[i] = 8'($urandom);
        if (zero_first) img_bytes[0] = 8'h00;
        for (int w = 0; w < NIMG/4; w++)
            img_mem[w] = {img_bytes[4*w+3], img_bytes[4*w+2], img_bytes[4*w+1], img_bytes[4*w]};
    endtask

    task automatic start_xfer(output int c0);
        rd_addr_q.delete(); wr_addr_q.delete(); wr_be_q.delete(); wr_data_q.delete();
        @(negedge clk);
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_cleared", done, 0);
        check("error_cleared", error, 0);
    endtask

    // Decode one 8N1 frame from tx_out, sampling every cycle; scyc is -1 when no start bit is found.
    task automatic get_tx_byte(output logic [7:0] b, output int scyc, output int ecyc, output bit ok);
        int guard = 0;
        logic [9:0] bits = '0;
        logic first = 1'b0;
        bit stable = 1'b1;
        while (tx_out !== 1'b0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        scyc = (tx_out === 1'b0) ? cyc : -1;
        if (scyc >= 0) begin
            for (int k = 0; k < 10*CPB; k++) begin
                if (k > 0) @(negedge clk);
                if (k % CPB == 0) first = tx_out;
                else if (tx_out !== first) stable = 1'b0;
                if (k % CPB == CPB/2) bits[k/CPB] = tx_out;
            end
        end
        ecyc = cyc;
        b    = bits[8:1];
        ok   = (scyc >= 0) && stable && (bits[0] == 1'b0) && (bits[9] == 1'b1);
    endtask

    // Expected stream: 0x55 then the image bytes in address order, 2 idle cycles between frames.
    task automatic run_tx(input int c0, output int last_cyc);
        logic [7:0] b;
        int s, e, prev_end;
        bit ok;
        prev_end = c0 - 2;
        last_cyc = -1;
        for (int k = 0; k <= NIMG; k++) begin
            get_tx_byte(b, s, e, ok);
            check("tx_frame", ok, 1);
            if (s < 0) return;
            check("tx_byte", b, (k == 0) ? 8'h55 : img_bytes[k-1]);
            check("tx_start_cyc", s, prev_end + 3);
            prev_end = e;
        end
        last_cyc = prev_end;
        check("img_read_count", rd_addr_q.size(), NIMG);
        for (int i = 0; i < rd_addr_q.size() && i < NIMG; i++)
            check("img_addr", rd_addr_q[i], i / 4);
    endtask

    task automatic uart_send(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rx_in = f[j];
            repeat (CPB) @(negedge clk);
        end
        rx_in = 1'b1;
    endtask

    task automatic check_writes(input int n);
        check("dump_write_count", wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check("dump_addr", wr_addr_q[i], i / 4);
            check("dump_byte_en", wr_be_q[i], 32'(1) << (i % 4));
            check("dump_wr_data", wr_data_q[i], {4{reply[i]}});
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int c0, lend;

        repeat (3) @(negedge clk);
        check("rst_tx_out", tx_out, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_img_rd_en", img_rd_en, 0);
        check("rst_img_addr", img_addr, 0);
        check("rst_dump_wr_en", dump_wr_en, 0);
        check("rst_dump_addr", dump_addr, 0);
        check("rst_dump_byte_en", dump_byte_en, 0);
        check("rst_dump_wr_data", dump_wr_data, 0);
        rst_n = 1'b1;

        // Full transfer, with a short low glitch before the first reply byte.
        new_image(1'b0);
        start_xfer(c0);
        run_tx(c0, lend);
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (3*CPB) @(negedge clk);
        check("glitch_no_write", wr_addr_q.size(), 0);
        check("glitch_no_error", error, 0);
        check("glitch_still_busy", busy, 1);
        for (int i = 0; i < NDMP; i++) begin
            reply[i] = 8'($urandom);
            uart_send(reply[i], 1'b1);
        end
        repeat (4) @(negedge clk);
        check("done_set", done, 1);
        check("done_not_busy", busy, 0);
        check("done_no_error", error, 0);
        check("done_latency", done_rise_cyc, last_wr_cyc + 1);
        check_writes(NDMP);

        // Framing error on the fifth dump byte.
        new_image(1'b0);
        start_xfer(c0);
        run_tx(c0, lend);
        for (int i = 0; i < 4; i++) begin
            reply[i] = 8'($urandom);
            uart_send(reply[i], 1'b1);
        end
        check("ferr_pre_error", error, 0);
        check("ferr_pre_busy", busy, 1);
        uart_send(8'($urandom), 1'b0);
        repeat (2) @(negedge clk);
        check("ferr_error", error, 1);
        check("ferr_not_busy", busy, 0);
        check("ferr_not_done", done, 0);
        check_writes(4);

        // Silent link: timeout, with an extra start pulse while busy.
        new_image(1'b0);
        start_xfer(c0);
        fork
            run_tx(c0, lend);
            begin
                repeat (700) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (TO + 20) @(negedge clk);
        check("timeout_cycle", err_rise_cyc, lend + 1 + TO);
        check("timeout_error", error, 1);
        check("timeout_not_busy", busy, 0);
        check("timeout_no_write", wr_addr_q.size(), 0);

        // Asynchronous reset in the middle of the first image byte.
        new_image(1'b1);
        start_xfer(c0);
        repeat (10*CPB + 2 + 40) @(negedge clk);
        check("pre_reset_tx_low", tx_out, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_out", tx_out, 1);
        check("arst_busy", busy, 0);
        check("arst_img_rd_en", img_rd_en, 0);
        check("arst_img_addr", img_addr, 0);
        check("arst_done", done, 0);
        check("arst_error", error, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        new_image(1'b0);
        start_xfer(c0);
        run_tx(c0, lend);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
